// File: rtl/ser_to_par_if.sv
// Bus bundle for ser_to_par: serial input side, parallel word output side.
// Optional bitcnt signal exists only when SER_TO_PAR_BITCNT_EN is defined.
interface ser_to_par_if #(
    parameter int LENGTH = 8
);
    logic              enable;
    logic              direct;
    logic              ivalid;
    logic              idata;
    logic              ovalid;
    logic [LENGTH-1:0] odata;
`ifdef SER_TO_PAR_BITCNT_EN
    logic [$clog2(LENGTH)-1:0] bitcnt;

    modport master (output enable, direct, ivalid, idata, input ovalid, odata, bitcnt);
    modport slave  (input enable, direct, ivalid, idata, output ovalid, odata, bitcnt);
`else
    modport master (output enable, direct, ivalid, idata, input ovalid, odata);
    modport slave  (input enable, direct, ivalid, idata, output ovalid, odata);
`endif
endinterface

// File: rtl/ser_to_par.sv
// Serial-to-parallel converter: packs LENGTH accepted bits into a word with a one-cycle ovalid strobe.
// Optional feature macro: SER_TO_PAR_BITCNT_EN exposes the partial-word bit count on bus.bitcnt.
module ser_to_par #(
    parameter int LENGTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    ser_to_par_if.slave  bus
);
    localparam int CW = $clog2(LENGTH);

    logic [LENGTH-1:0] r_sr;
    logic [LENGTH-1:0] r_odata;
    logic [CW-1:0]     r_cnt;
    logic              r_ovalid;
    logic              r_dir;

    logic              w_accept;
    logic              w_restart;
    logic              w_last;
    logic [LENGTH-1:0] w_base;
    logic [LENGTH-1:0] w_shifted;

    // A direction change mid-word drops the partial word; the new bit starts a fresh one.
    always_comb begin
        w_accept  = bus.enable & bus.ivalid;
        w_restart = (bus.direct != r_dir) && (r_cnt != '0);
        w_last    = !w_restart && (r_cnt == CW'(LENGTH - 1));
        w_base    = w_restart ? '0 : r_sr;
        w_shifted = w_base;
        if (bus.direct)
            w_shifted = {bus.idata, w_base[LENGTH-1:1]};
        else
            w_shifted = {w_base[LENGTH-2:0], bus.idata};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sr     <= '0;
            r_odata  <= '0;
            r_cnt    <= '0;
            r_ovalid <= 1'b0;
            r_dir    <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            if (w_accept) begin
                r_dir <= bus.direct;
                r_sr  <= w_shifted;
                if (w_restart) begin
                    r_cnt <= CW'(1);
                end else if (w_last) begin
                    r_cnt    <= '0;
                    r_odata  <= w_shifted;
                    r_ovalid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.ovalid = r_ovalid;
    assign bus.odata  = r_odata;
`ifdef SER_TO_PAR_BITCNT_EN
    assign bus.bitcnt = r_cnt;
`endif
endmodule

// File: tb/tb_ser_to_par.sv
// Directed bench for ser_to_par (LENGTH=8) with an expected-word queue and a decoupled output monitor.
module tb_ser_to_par;
    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;

    logic [7:0] exp_q[$];
    int         cyc_q[$];
    logic [7:0] last_word;

    ser_to_par_if #(.LENGTH(8)) bus ();

    ser_to_par #(.LENGTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: act=%0h req=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            last_word = '0;
        end else if (bus.ovalid) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_ovalid", {56'd0, bus.odata}, 64'd0);
            end else begin
                logic [7:0] w;
                int c;
                w = exp_q.pop_front();
                c = cyc_q.pop_front();
                check(bus.odata == w, "word", {56'd0, bus.odata}, {56'd0, w});
                check(cyc == c, "latency", 64'(cyc), 64'(c));
                last_word = w;
            end
        end else begin
            check(bus.odata == last_word, "odata_hold", {56'd0, bus.odata}, {56'd0, last_word});
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b, input logic dir);
        @(negedge clock);
        bus.enable = 1'b1;
        bus.ivalid = 1'b1;
        bus.idata  = b;
        bus.direct = dir;
    endtask

    task automatic idle(input int n, input bit freeze);
        repeat (n) begin
            @(negedge clock);
            if (freeze) begin
                bus.enable = 1'b0;
                bus.ivalid = 1'b1;
                bus.idata  = 1'($urandom_range(0, 1));
                bus.direct = 1'($urandom_range(0, 1));
            end else begin
                bus.enable = 1'b1;
                bus.ivalid = 1'b0;
                bus.idata  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // bits[7] is the first bit sent; gap_len cycles of idle/freeze inserted after gap_at bits
    task automatic send_word(input logic [7:0] bits, input logic dir, input logic [7:0] exp,
                             input int gap_at, input int gap_len, input bit freeze);
        for (int i = 7; i >= 0; i--) begin
            if (gap_at != 0 && (8 - gap_at) == i + 1 && gap_len > 0) idle(gap_len, freeze);
            drive_bit(bits[i], dir);
`ifdef SER_TO_PAR_BITCNT_EN
            if (i == 6) check(bus.bitcnt == 3'd1, "bitcnt_first", 64'(bus.bitcnt), 64'd1);
`endif
            if (i == 0) begin
                exp_q.push_back(exp);
                cyc_q.push_back(cyc + 1);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        last_word  = '0;
        bus.enable = 1'b0;
        bus.direct = 1'b0;
        bus.ivalid = 1'b0;
        bus.idata  = 1'b0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        #1;
        check(bus.odata == 8'h00, "reset_odata", {56'd0, bus.odata}, 64'd0);
        check(bus.ovalid == 1'b0, "reset_ovalid", 64'(bus.ovalid), 64'd0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;

        // back-to-back continuous words
        send_word(8'b1101_0101, 1'b0, 8'hD5, 0, 0, 1'b0);
        send_word(8'b1011_1011, 1'b0, 8'hBB, 0, 0, 1'b0);
        idle(2, 1'b0);

        // bit order
        send_word(8'b1100_0000, 1'b1, 8'h03, 0, 0, 1'b0);
        send_word(8'b1100_0000, 1'b0, 8'hC0, 0, 0, 1'b0);

        // ivalid gaps, then enable freeze
        send_word(8'b1101_0101, 1'b0, 8'hD5, 4, 3, 1'b0);
        send_word(8'b0101_1010, 1'b0, 8'h5A, 3, 5, 1'b1);
        idle(2, 1'b0);

        // reset mid-word
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        bus.ivalid = 1'b0;
        #1;
        check(bus.odata == 8'h00, "midreset_odata", {56'd0, bus.odata}, 64'd0);
        check(bus.ovalid == 1'b0, "midreset_ovalid", 64'(bus.ovalid), 64'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        send_word(8'b1010_1010, 1'b0, 8'hAA, 0, 0, 1'b0);

        // direction toggle after 3 bits drops the partial word
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        send_word(8'b1011_0000, 1'b1, 8'h0D, 0, 0, 1'b0);

        idle(4, 1'b0);
        check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
